// File: rtl/tone_generator_if.sv
// ============================================================================
// Module  : tone_generator_if
// Brief   : Tone register / audio output bundle shared by tone_generator.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface tone_generator_if #(
  parameter int WIDTH    = 24,
  parameter int VOL_BITS = 3
);
  logic                tone_enable;
  logic [WIDTH-1:0]    tone_input;
  logic [VOL_BITS-1:0] volume;
  logic                square_wave_out;
  logic                pwm_out;
  logic                half_period_tick;

  modport master (
    output tone_enable, tone_input, volume,
    input  square_wave_out, pwm_out, half_period_tick
  );

  modport slave (
    input  tone_enable, tone_input, volume,
    output square_wave_out, pwm_out, half_period_tick
  );
endinterface

`default_nettype wire

// File: rtl/tone_generator.sv
// ============================================================================
// Module  : tone_generator
// Brief   : Square-wave tone generator with glitch-free period reload and
//           volume-gated PWM copy.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tone_generator #(
  parameter int WIDTH    = 24,
  parameter int VOL_BITS = 3
) (
  input  wire logic       clk,
  input  wire logic       rst,
  tone_generator_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t              r_state;
  logic [WIDTH-1:0]    r_counter;
  logic [WIDTH-1:0]    r_active_period;
  logic [VOL_BITS-1:0] r_pwm_cnt;
  logic                r_phase;
  logic                r_pwm;
  logic                r_tick;

  logic                w_boundary;
  logic                w_pwm_on;
  logic                w_start;

  assign w_boundary = (r_counter == (r_active_period - WIDTH'(1)));
  assign w_pwm_on   = (r_pwm_cnt < bus.volume);
  assign w_start    = bus.tone_enable && (bus.tone_input != '0);

  // pwm_out is gated with the phase being registered on the same edge so it
  // never extends past a falling edge of square_wave_out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= IDLE;
      r_counter       <= '0;
      r_active_period <= '0;
      r_pwm_cnt       <= '0;
      r_phase         <= 1'b0;
      r_pwm           <= 1'b0;
      r_tick          <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_counter <= '0;
          r_pwm_cnt <= '0;
          r_phase   <= 1'b0;
          r_pwm     <= 1'b0;
          r_tick    <= 1'b0;
          if (w_start) begin
            r_state         <= RUN;
            r_active_period <= bus.tone_input;
          end else begin
            r_active_period <= '0;
          end
        end
        RUN: begin
          if (!bus.tone_enable) begin
            r_state         <= IDLE;
            r_counter       <= '0;
            r_active_period <= '0;
            r_pwm_cnt       <= '0;
            r_phase         <= 1'b0;
            r_pwm           <= 1'b0;
            r_tick          <= 1'b0;
          end else if (w_boundary) begin
            r_counter <= '0;
            if (bus.tone_input == '0) begin
              r_state         <= IDLE;
              r_active_period <= '0;
              r_pwm_cnt       <= '0;
              r_phase         <= 1'b0;
              r_pwm           <= 1'b0;
              r_tick          <= 1'b0;
            end else begin
              r_active_period <= bus.tone_input;
              r_pwm_cnt       <= r_pwm_cnt + VOL_BITS'(1);
              r_phase         <= ~r_phase;
              r_pwm           <= ~r_phase & w_pwm_on;
              r_tick          <= 1'b1;
            end
          end else begin
            r_counter <= r_counter + WIDTH'(1);
            r_pwm_cnt <= r_pwm_cnt + VOL_BITS'(1);
            r_pwm     <= r_phase & w_pwm_on;
            r_tick    <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.square_wave_out  = r_phase;
  assign bus.pwm_out          = r_pwm;
  assign bus.half_period_tick = r_tick;

endmodule

`default_nettype wire

// File: tb/tb_tone_generator.sv
// ============================================================================
// Module  : tb_tone_generator
// Brief   : Directed + random stimulus against a countdown reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_tone_generator;
  localparam int WIDTH    = 24;
  localparam int VOL_BITS = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  tone_generator_if #(.WIDTH(WIDTH), .VOL_BITS(VOL_BITS)) bus ();

  tone_generator #(.WIDTH(WIDTH), .VOL_BITS(VOL_BITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic                en_v  = 1'b0;
  logic [WIDTH-1:0]    ti_v  = '0;
  logic [VOL_BITS-1:0] vol_v = '0;
  assign bus.tone_enable = en_v;
  assign bus.tone_input  = ti_v;
  assign bus.volume      = vol_v;

  int compared   = 0;
  int mismatched = 0;

  // Reference: cycles left in the current half-period and RUN cycles elapsed.
  bit m_run = 0;
  bit m_ph  = 0;
  int m_remain = 0;
  int m_elapsed = 0;
  bit m_sq = 0, m_pwm = 0, m_tick = 0;

  task automatic check(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_run = 0; m_ph = 0; m_remain = 0; m_elapsed = 0;
    m_sq = 0; m_pwm = 0; m_tick = 0;
  endtask

  task automatic model_edge();
    if (!rst) begin
      model_clear();
    end else if (!m_run) begin
      model_clear();
      if (en_v && ti_v != 0) begin
        m_run = 1;
        m_remain = int'(ti_v);
      end
    end else if (!en_v) begin
      model_clear();
    end else begin
      m_elapsed++;
      m_remain--;
      m_tick = 0;
      if (m_remain == 0) begin
        if (ti_v == 0) begin
          m_run = 0;
          m_ph  = 0;
        end else begin
          m_ph = !m_ph;
          m_tick = 1;
          m_remain = int'(ti_v);
        end
      end
      m_sq  = m_ph;
      m_pwm = m_ph && (((m_elapsed - 1) % (1 << VOL_BITS)) < int'(vol_v));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("square", bus.square_wave_out, m_sq);
    check("pwm", bus.pwm_out, m_pwm);
    check("tick", bus.half_period_tick, m_tick);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic async_reset();
    #2 rst = 1'b0;
    #1;
    model_clear();
    check("rst_square", bus.square_wave_out, 1'b0);
    check("rst_pwm", bus.pwm_out, 1'b0);
    check("rst_tick", bus.half_period_tick, 1'b0);
    run(2);
    rst = 1'b1;
  endtask

  initial begin
    run(2);
    rst = 1'b1;
    run(2);

    // basic tone N=4
    en_v = 1; ti_v = 4; vol_v = 7;
    run(30);
    // N=1 toggles every cycle
    ti_v = 1;
    run(12);
    // mid-phase reload is deferred to the boundary
    ti_v = 10;
    run(26);
    ti_v = 3;
    run(30);
    // enable with zero period, then start, then stop via zero period
    en_v = 0; run(2);
    en_v = 1; ti_v = 0; run(6);
    ti_v = 5; run(23);
    ti_v = 0; run(15);
    // volume sweep at N=64
    ti_v = 64;
    vol_v = 0; run(140);
    vol_v = 4; run(140);
    vol_v = 7; run(140);
    // drop enable mid-phase, then re-enable
    ti_v = 6; run(3);
    en_v = 0; run(3);
    en_v = 1; run(20);
    // async reset mid-phase
    async_reset();
    run(20);
    // very long period must not toggle early
    ti_v = {WIDTH{1'b1}};
    en_v = 0; run(1);
    en_v = 1; run(40);
    en_v = 0; run(2);

    // randomized stimulus
    en_v = 1; ti_v = 3;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 24) == 0) en_v = ~en_v;
      if ($urandom_range(0, 14) == 0) ti_v = WIDTH'($urandom_range(0, 6));
      if ($urandom_range(0, 29) == 0) vol_v = VOL_BITS'($urandom);
      if ($urandom_range(0, 199) == 0) async_reset();
      else step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
